// File: rtl/mips_fetch.sv
// Instruction fetch stage: owns the PC, runs a single-outstanding req/ready
// handshake to instruction memory and hands one instruction at a time to decode.
module mips_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        halted,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {FETCH, DROP, VALID, HALT} state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] inst_n, inst_pc_n, imem_addr_n;
  logic        inst_valid_n, imem_req_n, halted_n, fault_n;
  logic        halt_pending, halt_pending_n;
  logic        fault_pending, fault_pending_n;
  logic        resp, misaligned, stop, fault_evt, redir;

  always_comb begin
    state_n         = state;
    pc_n            = pc;
    inst_n          = inst;
    inst_pc_n       = inst_pc;
    inst_valid_n    = inst_valid;
    fault_n         = fetch_fault;
    halt_pending_n  = halt_pending;
    fault_pending_n = fault_pending;

    // Once a halt is pending, later halts and redirects are irrelevant.
    misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
    stop       = !halt_pending && (halt || misaligned);
    fault_evt  = !halt_pending && !halt && misaligned;
    redir      = !halt_pending && !halt && redirect_valid && !misaligned;
    resp       = imem_req && imem_ready;

    case (state)
      FETCH, DROP: begin
        if (resp) begin
          if (halt_pending || stop) begin
            state_n = HALT;
            fault_n = fetch_fault | fault_pending | fault_evt;
          end else if (redir) begin
            pc_n    = redirect_pc;
            state_n = FETCH;
          end else if (state == DROP) begin
            state_n = FETCH;
          end else begin
            inst_n       = imem_rdata;
            inst_pc_n    = pc;
            inst_valid_n = 1'b1;
            pc_n         = pc + 32'd4;
            state_n      = VALID;
          end
        end else if (stop) begin
          // An outstanding request must still complete before halting.
          if (imem_req) begin
            halt_pending_n  = 1'b1;
            fault_pending_n = fault_evt;
            state_n         = DROP;
          end else begin
            state_n = HALT;
            fault_n = fetch_fault | fault_evt;
          end
        end else if (redir) begin
          pc_n = redirect_pc;
          if (imem_req) state_n = DROP;
        end
      end
      VALID: begin
        if (stop) begin
          state_n      = HALT;
          inst_valid_n = 1'b0;
          fault_n      = fetch_fault | fault_evt;
        end else if (redir) begin
          pc_n         = redirect_pc;
          inst_valid_n = 1'b0;
          state_n      = FETCH;
        end else if (inst_ready) begin
          inst_valid_n = 1'b0;
          state_n      = FETCH;
        end
      end
      HALT: begin
        inst_valid_n = 1'b0;
      end
      default: begin
        state_n      = HALT;
        inst_valid_n = 1'b0;
      end
    endcase

    imem_req_n  = (state_n == FETCH) || (state_n == DROP);
    // Address is frozen while a request waits for its response.
    imem_addr_n = (imem_req && !imem_ready) ? imem_addr : pc_n;
    halted_n    = (state_n == HALT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= FETCH;
      pc            <= RESET_PC;
      inst          <= 32'd0;
      inst_pc       <= 32'd0;
      inst_valid    <= 1'b0;
      imem_req      <= 1'b0;
      imem_addr     <= RESET_PC;
      halted        <= 1'b0;
      fetch_fault   <= 1'b0;
      halt_pending  <= 1'b0;
      fault_pending <= 1'b0;
    end else begin
      state         <= state_n;
      pc            <= pc_n;
      inst          <= inst_n;
      inst_pc       <= inst_pc_n;
      inst_valid    <= inst_valid_n;
      imem_req      <= imem_req_n;
      imem_addr     <= imem_addr_n;
      halted        <= halted_n;
      fetch_fault   <= fault_n;
      halt_pending  <= halt_pending_n;
      fault_pending <= fault_pending_n;
    end
  end

endmodule

// File: tb/tb_mips_fetch.sv
// Directed bench for mips_fetch: variable-latency memory model, scoreboard of
// expected delivered instructions, and cycle-level checks of the handshakes.
module tb_mips_fetch;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        halted;
  logic        fetch_fault;

  int n_cmp = 0;
  int n_bad = 0;
  int lat   = 1;
  int wait_cnt = 0;
  logic [31:0] req_addr;
  logic [31:0] req_log[$];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;
  exp_t sb[$];

  mips_fetch #(.RESET_PC(32'h0040_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt(halt), .halted(halted), .fetch_fault(fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] a);
    exp_t e;
    e.pc   = a;
    e.word = mem_word(a);
    return e;
  endfunction

  // Memory: answers each request after `lat` cycles and checks request stability.
  always @(negedge clk) begin
    if (rst || !imem_req) begin
      wait_cnt   = 0;
      imem_ready = 1'b0;
    end else begin
      if (imem_ready) wait_cnt = 0;
      wait_cnt++;
      if (wait_cnt == 1) begin
        req_addr = imem_addr;
        req_log.push_back(imem_addr);
        chk("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
      end else begin
        chk("addr_stable", imem_addr, req_addr);
      end
      imem_ready = (wait_cnt >= lat);
      imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hDEAD_BEEF;
    end
  end

  // Scoreboard: every accepted instruction must match the next expected entry.
  always @(negedge clk) begin
    #1;
    if (inst_valid && inst_ready && !redirect_valid && !halt) begin
      n_cmp++;
      assert (sb.size() != 0) else begin
        n_bad++;
        $error("FAIL unexpected_inst: observed pc %h expected no delivery", inst_pc);
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_pc", inst_pc, e.pc);
        chk("sb_inst", inst, e.word);
      end
    end
  end

  task automatic do_reset();
    #2;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    halt           = 1'b0;
    inst_ready     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    req_log.delete();
    rst = 1'b0;
  endtask

  task automatic wait_valid(input int max, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk);
      seen = inst_valid;
    end
    chk(tag, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int hits;
    rst            = 1'b1;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    halt           = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_imem_addr", imem_addr, 32'h0040_0000);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_fault", {31'd0, fetch_fault}, 32'd0);

    // 1-cycle memory, decode always ready: one instruction every 2 cycles.
    for (int k = 0; k < 3; k++) sb.push_back(mk(32'h0040_0000 + 32'(4 * k)));
    lat        = 1;
    inst_ready = 1'b1;
    rst        = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t1_req", {31'd0, imem_req}, 32'd1);
      chk("t1_addr", imem_addr, 32'h0040_0000 + 32'(4 * k));
      chk("t1_gap_valid", {31'd0, inst_valid}, 32'd0);
      @(negedge clk);
      chk("t1_valid", {31'd0, inst_valid}, 32'd1);
      chk("t1_req_idle", {31'd0, imem_req}, 32'd0);
      chk("t1_inst_pc", inst_pc, 32'h0040_0000 + 32'(4 * k));
    end

    // 3-cycle memory, decode stalls 4 cycles.
    lat = 3;
    do_reset();
    sb.push_back(mk(32'h0040_0000));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t2_req_hold", {31'd0, imem_req}, 32'd1);
      chk("t2_addr_hold", imem_addr, 32'h0040_0000);
      chk("t2_no_valid", {31'd0, inst_valid}, 32'd0);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t2_stall_valid", {31'd0, inst_valid}, 32'd1);
      chk("t2_stall_inst", inst, mem_word(32'h0040_0000));
      chk("t2_stall_pc", inst_pc, 32'h0040_0000);
      chk("t2_stall_noreq", {31'd0, imem_req}, 32'd0);
    end
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    chk("t2_next_req", {31'd0, imem_req}, 32'd1);
    chk("t2_next_addr", imem_addr, 32'h0040_0004);
    chk("t2_released", {31'd0, inst_valid}, 32'd0);

    // Redirect in the 2nd wait cycle of a 3-cycle request.
    lat = 3;
    do_reset();
    inst_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0040_0100;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("t3_req_kept", {31'd0, imem_req}, 32'd1);
    chk("t3_addr_kept", imem_addr, 32'h0040_0000);
    @(negedge clk);
    chk("t3_dropped", {31'd0, inst_valid}, 32'd0);
    chk("t3_new_req", {31'd0, imem_req}, 32'd1);
    chk("t3_new_addr", imem_addr, 32'h0040_0100);
    sb.push_back(mk(32'h0040_0100));
    wait_valid(10, "t3_target_valid");

    // Redirect together with inst_ready in VALID.
    lat = 1;
    do_reset();
    @(negedge clk);
    @(negedge clk);
    chk("t4_valid", {31'd0, inst_valid}, 32'd1);
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0040_0200;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("t4_squashed", {31'd0, inst_valid}, 32'd0);
    chk("t4_req", {31'd0, imem_req}, 32'd1);
    chk("t4_target", imem_addr, 32'h0040_0200);
    sb.push_back(mk(32'h0040_0200));
    wait_valid(10, "t4_target_valid");

    // Halt during an outstanding request, redirect one cycle later.
    lat = 3;
    do_reset();
    @(negedge clk);
    chk("t5_req", {31'd0, imem_req}, 32'd1);
    halt = 1'b1;
    @(negedge clk);
    halt           = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0040_0300;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("t5_req_kept", {31'd0, imem_req}, 32'd1);
    chk("t5_addr_kept", imem_addr, 32'h0040_0000);
    chk("t5_not_yet_halted", {31'd0, halted}, 32'd0);
    inst_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t5_halted", {31'd0, halted}, 32'd1);
      chk("t5_noreq", {31'd0, imem_req}, 32'd0);
      chk("t5_novalid", {31'd0, inst_valid}, 32'd0);
      chk("t5_nofault", {31'd0, fetch_fault}, 32'd0);
    end
    chk("t5_req_count", 32'(req_log.size()), 32'd1);
    lat = 1;
    do_reset();
    @(negedge clk);
    chk("t5_restart_req", {31'd0, imem_req}, 32'd1);
    chk("t5_restart_addr", imem_addr, 32'h0040_0000);
    chk("t5_restart_halted", {31'd0, halted}, 32'd0);

    // PC wrap from 0xFFFFFFFC.
    lat = 1;
    do_reset();
    inst_ready = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("t6_top_addr", imem_addr, 32'hFFFF_FFFC);
    chk("t6_top_req", {31'd0, imem_req}, 32'd1);
    chk("t6_top_novalid", {31'd0, inst_valid}, 32'd0);
    sb.push_back(mk(32'hFFFF_FFFC));
    sb.push_back(mk(32'h0000_0000));
    wait_valid(10, "t6_top_valid");
    @(negedge clk);
    chk("t6_wrap_addr", imem_addr, 32'h0000_0000);
    chk("t6_wrap_req", {31'd0, imem_req}, 32'd1);
    wait_valid(10, "t6_wrap_valid");

    // Misaligned redirect target.
    lat = 1;
    do_reset();
    @(negedge clk);
    @(negedge clk);
    chk("t7_valid", {31'd0, inst_valid}, 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0040_0102;
    @(negedge clk);
    redirect_valid = 1'b0;
    inst_ready     = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("t7_fault", {31'd0, fetch_fault}, 32'd1);
      chk("t7_halted", {31'd0, halted}, 32'd1);
      chk("t7_noreq", {31'd0, imem_req}, 32'd0);
      chk("t7_novalid", {31'd0, inst_valid}, 32'd0);
      @(negedge clk);
    end
    hits = 0;
    foreach (req_log[i])
      if (req_log[i] == 32'h0040_0100 || req_log[i] == 32'h0040_0102) hits++;
    chk("t7_no_bad_req", 32'(hits), 32'd0);
    chk("t7_req_count", 32'(req_log.size()), 32'd1);

    #2;
    chk("sb_final_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
